game_status_fsm: RTL

//  Game-level state controller for the Pacman datapath. Counts pellets, tracks

---
 rtl/game_status_fsm.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/game_status_fsm.sv
// Game-level controller for the Pacman datapath: pellets, lives, score and win/lose levels.
// Optional play timer enabled by defining GAME_TIMEOUT_EN; otherwise time_left is tied to 0.
module game_status_fsm #(
    parameter int NUM_PELLETS    = 244,
    parameter int LIVES          = 3,
    parameter int DEATH_FRAMES   = 60,
    parameter int SCORE_STEP     = 10,
    parameter int TIMEOUT_FRAMES = 10800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        pellet_eaten,
    input  logic        ghost_contact,
    output logic        playing,
    output logic        respawn,
    output logic        gamewin,
    output logic        gamelose,
    output logic [2:0]  lives,
    output logic [15:0] score,
    output logic [8:0]  pellets_left,
    output logic [13:0] time_left
);

    localparam int DW = $clog2(DEATH_FRAMES + 1);

    localparam logic [2:0]    LIVES_INIT   = 3'(LIVES);
    localparam logic [8:0]    PELLETS_INIT = 9'(NUM_PELLETS);
    localparam logic [DW-1:0] DEATH_LAST   = DW'(DEATH_FRAMES - 1);

    generate
        if (LIVES < 1 || LIVES > 7) begin : g_bad_lives
            $error("game_status_fsm: LIVES must be in 1..7");
        end
        if (DEATH_FRAMES < 1) begin : g_bad_death
            $error("game_status_fsm: DEATH_FRAMES must be at least 1");
        end
        if (TIMEOUT_FRAMES < 1 || TIMEOUT_FRAMES > 16383) begin : g_bad_timeout
            $error("game_status_fsm: TIMEOUT_FRAMES must fit time_left and be nonzero");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        DYING,
        WIN,
        LOSE
    } state_t;

    state_t        state, state_next;
    logic          start_q;
    logic          start_rise;
    logic [DW-1:0] death_cnt, death_cnt_next;
    logic          respawn_next;
    logic [2:0]    lives_next;
    logic [15:0]   score_next;
    logic [8:0]    pellets_next;
    logic [13:0]   time_next;
    logic [16:0]   score_sum;
    logic          last_pellet;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_next     = state;
        death_cnt_next = death_cnt;
        respawn_next   = 1'b0;
        lives_next     = lives;
        score_next     = score;
        pellets_next   = pellets_left;
        time_next      = time_left;
        start_rise     = start & ~start_q;
        score_sum      = {1'b0, score} + 17'(SCORE_STEP);
        last_pellet    = pellet_eaten && (pellets_left == 9'd1);

        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_next     = PLAY;
                    lives_next     = LIVES_INIT;
                    score_next     = '0;
                    pellets_next   = PELLETS_INIT;
                    death_cnt_next = '0;
`ifdef GAME_TIMEOUT_EN
                    time_next      = 14'(TIMEOUT_FRAMES);
`endif
                end
            end

            PLAY: begin
                if (pellet_eaten && pellets_left != 9'd0) begin
                    pellets_next = pellets_left - 9'd1;
                    score_next   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end
`ifdef GAME_TIMEOUT_EN
                if (frame_tick && time_left != 14'd0) begin
                    time_next = time_left - 14'd1;
                end
`endif
                // The last pellet wins outright and swallows any simultaneous ghost contact.
                if (last_pellet) begin
                    state_next = WIN;
                end else begin
                    if (ghost_contact && lives != 3'd0) begin
                        lives_next     = lives - 3'd1;
                        state_next     = (lives == 3'd1) ? LOSE : DYING;
                        death_cnt_next = '0;
                    end
`ifdef GAME_TIMEOUT_EN
                    if (frame_tick && time_left == 14'd1) begin
                        state_next = LOSE;
                    end
`endif
                end
            end

            DYING: begin
                if (frame_tick) begin
                    if (death_cnt == DEATH_LAST) begin
                        state_next     = PLAY;
                        respawn_next   = 1'b1;
                        death_cnt_next = '0;
                    end else begin
                        death_cnt_next = death_cnt + 1'b1;
                    end
                end
            end

            WIN, LOSE: begin
                if (start_rise) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

`ifndef GAME_TIMEOUT_EN
        time_next = '0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            death_cnt    <= '0;
            playing      <= 1'b0;
            respawn      <= 1'b0;
            gamewin      <= 1'b0;
            gamelose     <= 1'b0;
            lives        <= '0;
            score        <= '0;
            pellets_left <= PELLETS_INIT;
            time_left    <= '0;
        end else begin
            state        <= state_next;
            start_q      <= start;
            death_cnt    <= death_cnt_next;
            playing      <= (state_next == PLAY);
            respawn      <= respawn_next;
            gamewin      <= (state_next == WIN);
            gamelose     <= (state_next == LOSE);
            lives        <= lives_next;
            score        <= score_next;
            pellets_left <= pellets_next;
            time_left    <= time_next;
        end
    end

endmodule
